// File: rtl/cordic_req_sched_pkg.sv
// Shared definitions for the CORDIC request scheduler.
// Contents:
//   ANGLE_MAX      first out-of-range angle in integer degrees
//   DATA_W_DEFAULT default cos/sin width (signed Q16.16)
//   state_e        one-hot scheduler FSM encoding
package cordic_req_sched_pkg;

    localparam int unsigned ANGLE_MAX      = 360;
    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StIssue = 4'b0010,
        StWait  = 4'b0100,
        StResp  = 4'b1000
    } state_e;

endpackage

// File: rtl/cordic_req_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request searching ptr, ptr+1, ... (mod N).
// Ports:
//   req_i  [N-1:0]     request vector
//   ptr_i  [IdxW-1:0]  highest-priority index this round
//   gnt_o  [N-1:0]     one-hot grant (all zero when no request)
//   idx_o  [IdxW-1:0]  index of the granted request
//   any_o              at least one request asserted
module cordic_req_sched_rr_arbiter #(
    parameter  int unsigned N    = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    logic [2*N-1:0]  req_rot;
    logic [IdxW-1:0] offset;
    logic [IdxW:0]   idx_sum;

    always_comb begin
        // Rotate so that bit 0 is the requester at ptr; the doubled vector makes the wrap free.
        req_rot = {req_i, req_i} >> ptr_i;
        offset  = '0;
        any_o   = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!any_o && req_rot[i]) begin
                any_o  = 1'b1;
                offset = IdxW'(i);
            end
        end
        idx_sum = {1'b0, ptr_i} + {1'b0, offset};
        if (idx_sum >= (IdxW + 1)'(N)) begin
            idx_sum = idx_sum - (IdxW + 1)'(N);
        end
        idx_o = idx_sum[IdxW-1:0];
        gnt_o = any_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/cordic_req_sched.sv
// Shares one CORDIC rotate engine between NUM_REQ requesters.
// Requests are granted round-robin, issued one at a time, and answered on a single
// tagged valid/ready response channel. A watchdog aborts engine waits after TIMEOUT cycles.
// Ports:
//   clk_i                      clock, rising edge
//   rst_i                      synchronous active-high reset
//   req_valid_i [NUM_REQ]      per-requester request valid
//   req_angle_i [NUM_REQ*AW]   packed angles, slice i = [i*ANGLE_W +: ANGLE_W]
//   req_ready_o [NUM_REQ]      one-hot accept pulse (IDLE only)
//   eng_start_o                one-cycle engine issue pulse
//   eng_angle_o [ANGLE_W]      engine angle, stable from ISSUE through WAIT
//   eng_valid_i                engine result strobe
//   eng_cos_i/eng_sin_i        engine results
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_id_o                   owning requester index
//   rsp_cos_o/rsp_sin_o        result (zero on error)
//   rsp_err_o                  angle >= 360 or engine timeout
//   busy_o                     FSM not idle
module cordic_req_sched
    import cordic_req_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned ANGLE_W = 16,
    parameter  int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter  int unsigned TIMEOUT = 63,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*ANGLE_W-1:0] req_angle_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       eng_start_o,
    output logic [ANGLE_W-1:0]         eng_angle_o,
    input  logic                       eng_valid_i,
    input  logic [DATA_W-1:0]          eng_cos_i,
    input  logic [DATA_W-1:0]          eng_sin_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [ID_W-1:0]            rsp_id_o,
    output logic [DATA_W-1:0]          rsp_cos_o,
    output logic [DATA_W-1:0]          rsp_sin_o,
    output logic                       rsp_err_o,
    output logic                       busy_o
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    // Compare width wide enough to hold 360 even for narrow angle buses.
    localparam int unsigned CMP_W = (ANGLE_W > 9) ? ANGLE_W : 9;

    state_e              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [TMR_W-1:0]    timer_q;
    logic                eng_start_q;
    logic [ANGLE_W-1:0]  eng_angle_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_cos_q;
    logic [DATA_W-1:0]   rsp_sin_q;
    logic                rsp_err_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_any;
    logic [ANGLE_W-1:0]  angle_sel;
    logic                angle_bad;
    logic [TMR_W-1:0]    timer_inc;
    logic                timer_expired;
    logic [ID_W-1:0]     ptr_next;

    cordic_req_sched_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        angle_sel     = req_angle_i[arb_idx*ANGLE_W +: ANGLE_W];
        angle_bad     = CMP_W'(angle_sel) >= CMP_W'(ANGLE_MAX);
        // WAIT lasts at most TIMEOUT cycles: abort when the incremented count reaches TIMEOUT.
        timer_inc     = timer_q + 1'b1;
        timer_expired = (timer_inc == TMR_W'(TIMEOUT));
        ptr_next      = (int'(rsp_id_q) == int'(NUM_REQ) - 1) ? '0 : rsp_id_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            timer_q     <= '0;
            eng_start_q <= 1'b0;
            eng_angle_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_cos_q   <= '0;
            rsp_sin_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        rsp_id_q <= arb_idx;
                        if (angle_bad) begin
                            // Out-of-range angle is answered without touching the engine.
                            rsp_valid_q <= 1'b1;
                            rsp_cos_q   <= '0;
                            rsp_sin_q   <= '0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            eng_angle_q <= angle_sel;
                            eng_start_q <= 1'b1;
                            state_q     <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    timer_q <= timer_inc;
                    // A result in the expiry cycle still wins.
                    if (eng_valid_i) begin
                        rsp_valid_q <= 1'b1;
                        rsp_cos_q   <= eng_cos_i;
                        rsp_sin_q   <= eng_sin_i;
                        rsp_err_q   <= 1'b0;
                        state_q     <= StResp;
                    end else if (timer_expired) begin
                        rsp_valid_q <= 1'b1;
                        rsp_cos_q   <= '0;
                        rsp_sin_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ptr_next;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == StIdle) ? arb_gnt : '0;
    assign eng_start_o = eng_start_q;
    assign eng_angle_o = eng_angle_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_cos_o   = rsp_cos_q;
    assign rsp_sin_o   = rsp_sin_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_cordic_req_sched.sv
module tb_cordic_req_sched;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 63;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_angle;
    logic [NR-1:0]     req_ready;
    logic              eng_start;
    logic [AW-1:0]     eng_angle;
    logic              eng_valid;
    logic [DW-1:0]     eng_cos;
    logic [DW-1:0]     eng_sin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_cos;
    logic [DW-1:0]     rsp_sin;
    logic              rsp_err;
    logic              busy;

    cordic_req_sched #(
        .NUM_REQ (NR),
        .ANGLE_W (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_angle_i (req_angle),
        .req_ready_o (req_ready),
        .eng_start_o (eng_start),
        .eng_angle_o (eng_angle),
        .eng_valid_i (eng_valid),
        .eng_cos_i   (eng_cos),
        .eng_sin_i   (eng_sin),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_cos_o   (rsp_cos),
        .rsp_sin_o   (rsp_sin),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] cos;
        logic [DW-1:0] sin;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Engine model: mode 0 derives results from the angle, 1 returns fixed values, 2 is silent.
    int            eng_mode = 0;
    int            eng_lat  = 19;
    int            n_start  = 0;
    logic [DW-1:0] fix_cos  = '0;
    logic [DW-1:0] fix_sin  = '0;

    function automatic logic [DW-1:0] mdl_cos(logic [AW-1:0] a);
        return {16'hC0C0, a};
    endfunction

    function automatic logic [DW-1:0] mdl_sin(logic [AW-1:0] a);
        return {16'h5151, a};
    endfunction

    task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        logic [AW-1:0] a;
        eng_valid = 1'b0;
        eng_cos   = '0;
        eng_sin   = '0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                n_start++;
                a = eng_angle;
                if (eng_mode != 2) begin
                    repeat (eng_lat) @(posedge clk);
                    #1;
                    eng_valid = 1'b1;
                    eng_cos   = (eng_mode == 1) ? fix_cos : mdl_cos(a);
                    eng_sin   = (eng_mode == 1) ? fix_sin : mdl_sin(a);
                    @(posedge clk);
                    #1;
                    eng_valid = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: pops one expectation per accepted response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    bound_fail("unexpected_rsp");
                end else begin
                    e = sb.pop_front();
                    check("rsp_id",  128'(rsp_id),  128'(e.id));
                    check("rsp_cos", 128'(rsp_cos), 128'(e.cos));
                    check("rsp_sin", 128'(rsp_sin), 128'(e.sin));
                    check("rsp_err", 128'(rsp_err), 128'(e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int idx, input logic [AW-1:0] ang, input exp_t e,
                         output int acc_cyc);
        req_angle[idx*AW +: AW] = ang;
        req_valid[idx] = 1'b1;
        acc_cyc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (req_ready[idx] === 1'b1) begin
                acc_cyc = cyc;
                break;
            end
        end
        if (acc_cyc < 0) begin
            bound_fail("accept_wait");
        end else begin
            check("req_ready_onehot", 128'(req_ready), 128'(NR'(1) << idx));
            sb.push_back(e);
        end
        tick();
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(output int c);
        c = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) bound_fail("rsp_wait");
    endtask

    task automatic wait_done();
        int ok;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (busy === 1'b0 && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) bound_fail("done_wait");
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   acc;
        int   rc;
        int   ns;
        int   got;
        int   order[5];
        int   exp_order[5];
        logic [AW-1:0] ang4[4];
        logic [2+IW+2*DW-1:0] snap;

        rst       = 1'b1;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs",
              128'({req_ready, eng_start, eng_angle, rsp_valid, rsp_id, rsp_cos, rsp_sin,
                    rsp_err, busy}), 128'(0));
        tick();
        rst = 1'b0;
        tick();

        // Single legal request with fixed engine values.
        eng_mode = 1;
        eng_lat  = 19;
        fix_cos  = 32'h0000_DDB3;
        fix_sin  = 32'h0000_8000;
        issue(1, 16'd30, '{id: 2'd1, cos: 32'h0000_DDB3, sin: 32'h0000_8000, err: 1'b0}, acc);
        wait_rsp(rc);
        check("latency_l19", 128'(rc - acc), 128'(19 + 2));
        wait_done();

        // Range errors bypass the engine; 359 is still legal.
        ns = n_start;
        issue(2, 16'd400, '{id: 2'd2, cos: '0, sin: '0, err: 1'b1}, acc);
        wait_rsp(rc);
        check("range_err_latency", 128'(rc - acc), 128'(1));
        wait_done();
        issue(3, 16'd360, '{id: 2'd3, cos: '0, sin: '0, err: 1'b1}, acc);
        wait_done();
        check("no_eng_start_on_err", 128'(n_start), 128'(ns));
        eng_mode = 0;
        eng_lat  = 3;
        issue(0, 16'd359, '{id: 2'd0, cos: mdl_cos(16'd359), sin: mdl_sin(16'd359), err: 1'b0},
              acc);
        wait_done();

        // Silent engine: timeout, then a normal request.
        eng_mode = 2;
        issue(1, 16'd90, '{id: 2'd1, cos: '0, sin: '0, err: 1'b1}, acc);
        wait_rsp(rc);
        check("timeout_latency", 128'(rc - acc), 128'(TO + 2));
        wait_done();
        eng_mode = 0;
        eng_lat  = 5;
        issue(2, 16'd180, '{id: 2'd2, cos: mdl_cos(16'd180), sin: mdl_sin(16'd180), err: 1'b0},
              acc);
        wait_rsp(rc);
        check("latency_l5", 128'(rc - acc), 128'(5 + 2));
        wait_done();

        // Result in the last WAIT cycle wins; one cycle later it is a timeout.
        eng_lat = TO;
        issue(3, 16'd270, '{id: 2'd3, cos: mdl_cos(16'd270), sin: mdl_sin(16'd270), err: 1'b0},
              acc);
        wait_rsp(rc);
        check("boundary_result_latency", 128'(rc - acc), 128'(TO + 2));
        wait_done();
        eng_lat = TO + 1;
        issue(0, 16'd10, '{id: 2'd0, cos: '0, sin: '0, err: 1'b1}, acc);
        wait_rsp(rc);
        check("late_result_timeout", 128'(rc - acc), 128'(TO + 2));
        wait_done();
        repeat (4) tick();

        // Backpressure: response held stable, no new grants.
        eng_lat   = 3;
        rsp_ready = 1'b0;
        issue(1, 16'd45, '{id: 2'd1, cos: mdl_cos(16'd45), sin: mdl_sin(16'd45), err: 1'b0}, acc);
        req_angle[3*AW +: AW] = 16'd120;
        req_valid[3] = 1'b1;
        wait_rsp(rc);
        snap = {rsp_valid, rsp_err, rsp_id, rsp_cos, rsp_sin};
        check("hold_snapshot_valid", 128'(snap[2+IW+2*DW-1]), 128'(1));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_stable", 128'({rsp_valid, rsp_err, rsp_id, rsp_cos, rsp_sin}),
                  128'(snap));
            check("hold_no_ready", 128'(req_ready), 128'(0));
        end
        tick();
        rsp_ready = 1'b1;
        issue(3, 16'd120, '{id: 2'd3, cos: mdl_cos(16'd120), sin: mdl_sin(16'd120), err: 1'b0},
              acc);
        wait_done();

        // Reset while waiting on the engine; the late result must be ignored.
        eng_lat = 19;
        issue(0, 16'd45, '{id: 2'd0, cos: mdl_cos(16'd45), sin: mdl_sin(16'd45), err: 1'b0}, acc);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check("post_reset_quiet",
                  128'({req_ready, eng_start, eng_angle, rsp_valid, rsp_id, rsp_cos, rsp_sin,
                        rsp_err, busy}), 128'(0));
        end
        tick();

        // All four requesting continuously: pointer restarts at 0.
        eng_lat   = 3;
        ang4[0]   = 16'd10;
        ang4[1]   = 16'd20;
        ang4[2]   = 16'd30;
        ang4[3]   = 16'd40;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NR; i++) req_angle[i*AW +: AW] = ang4[i];
        req_valid = '1;
        got = 0;
        for (int k = 0; k < 400 && got < 5; k++) begin
            @(negedge clk);
            if (req_ready !== '0) begin
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i] === 1'b1) order[got] = i;
                end
                check("rr_onehot", 128'($countones(req_ready)), 128'(1));
                sb.push_back('{id: IW'(order[got]), cos: mdl_cos(ang4[order[got]]),
                               sin: mdl_sin(ang4[order[got]]), err: 1'b0});
                got++;
                if (got == 5) begin
                    tick();
                    req_valid = '0;
                end
            end
        end
        if (got < 5) begin
            bound_fail("rr_grants");
            req_valid = '0;
        end
        for (int i = 0; i < got; i++) check("rr_order", 128'(order[i]), 128'(exp_order[i]));
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
